// File: rtl/ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
// Shared constants for the multicycle control FSM:
//   - opcode encodings decoded in the Decode state
//   - state register encodings (S_RST .. S_BR)
//   - PC_Sel mux encodings
//   - an opcode classifier used by the Decode branch
// -----------------------------------------------------------------------------
package ctrl_pkg;

  // Opcode field values (IR[31:26])
  localparam logic [5:0] OP_R    = 6'b100000;
  localparam logic [5:0] OP_ADDI = 6'b110000;
  localparam logic [5:0] OP_LI   = 6'b111000;
  localparam logic [5:0] OP_LW   = 6'b001111;
  localparam logic [5:0] OP_SW   = 6'b011111;
  localparam logic [5:0] OP_B    = 6'b111111;
  localparam logic [5:0] OP_BEQ  = 6'b000000;

  // State encodings; codes 11..15 are unused and recover to S_RST
  localparam logic [3:0] S_RST    = 4'd0;
  localparam logic [3:0] S_IF     = 4'd1;
  localparam logic [3:0] S_DEC    = 4'd2;
  localparam logic [3:0] S_EXE_R  = 4'd3;
  localparam logic [3:0] S_EXE_I  = 4'd4;
  localparam logic [3:0] S_ADDR   = 4'd5;
  localparam logic [3:0] S_MEM_RD = 4'd6;
  localparam logic [3:0] S_MEM_WR = 4'd7;
  localparam logic [3:0] S_WB_ALU = 4'd8;
  localparam logic [3:0] S_WB_MEM = 4'd9;
  localparam logic [3:0] S_BR     = 4'd10;

  // PC_Sel mux encodings
  localparam logic [1:0] PCS_SEQ  = 2'b00;  // PC + 4
  localparam logic [1:0] PCS_BR   = 2'b01;  // PC + 4 + (Imm << 2)
  localparam logic [1:0] PCS_HOLD = 2'b10;  // hold current PC

  // Instruction class, used to pick the Decode successor state
  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_MEM,
    CLS_BR,
    CLS_ILL
  } op_class_t;

  function automatic op_class_t classify(input logic [5:0] opcode);
    op_class_t cls;
    case (opcode)
      OP_R:          cls = CLS_R;
      OP_ADDI, OP_LI: cls = CLS_I;
      OP_LW, OP_SW:  cls = CLS_MEM;
      OP_B, OP_BEQ:  cls = CLS_BR;
      default:       cls = CLS_ILL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Control FSM for the multicycle datapath. Sequences Fetch / Decode / Execute /
// Memory / Writeback and produces every register write enable and mux select.
// Memory accesses complete on Mem_Ack; enables that commit a memory result
// (IR_WE/PC_WE in fetch, MDR_WE in load) are gated by Mem_Ack in that cycle.
//
// Ports:
//   Clk, Reset_n          rising-edge clock, asynchronous active-low reset
//   Opcode   [OPC_W-1:0]  IR[31:26], valid from Decode onward
//   Zero                  ALU zero flag, used in S_BR for BEQ
//   Mem_Ack               completes the current memory access
//   PC_WE, IR_WE, AB_WE, ALUOut_WE, MDR_WE, RF_WE   register write enables
//   Mem_RE, Mem_WE        memory read / write requests (never both high)
//   PC_Sel   [1:0]        00=PC+4, 01=branch target, 10=hold
//   ALUSrc_Sel            0=B, 1=sign-extended immediate
//   WB_Sel                0=ALUOut, 1=MDR
//   Illegal_Op            one-cycle pulse in Decode on an unknown opcode
// -----------------------------------------------------------------------------
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OPC_W = 6,
  parameter int ST_W  = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [OPC_W-1:0] Opcode,
  input  logic             Zero,
  input  logic             Mem_Ack,
  output logic             PC_WE,
  output logic             IR_WE,
  output logic             AB_WE,
  output logic             ALUOut_WE,
  output logic             MDR_WE,
  output logic             RF_WE,
  output logic             Mem_RE,
  output logic             Mem_WE,
  output logic [1:0]       PC_Sel,
  output logic             ALUSrc_Sel,
  output logic             WB_Sel,
  output logic             Illegal_Op
);

  logic [ST_W-1:0] state_q, state_d;
  op_class_t       op_cls;

  assign op_cls = classify(Opcode);

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_RST;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples the pre-edge values of its inputs.
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch forms.
    state_d = state_q;
    case (state_q)
      S_RST:    state_d = S_IF;
      S_IF:     if (Mem_Ack) state_d = S_DEC;
      S_DEC: begin
        case (op_cls)
          CLS_R:   state_d = S_EXE_R;
          CLS_I:   state_d = S_EXE_I;
          CLS_MEM: state_d = S_ADDR;
          CLS_BR:  state_d = S_BR;
          default: state_d = S_IF;
        endcase
      end
      S_EXE_R:  state_d = S_WB_ALU;
      S_EXE_I:  state_d = S_WB_ALU;
      S_ADDR:   state_d = (Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (Mem_Ack) state_d = S_WB_MEM;
      S_MEM_WR: if (Mem_Ack) state_d = S_IF;
      S_WB_ALU: state_d = S_IF;
      S_WB_MEM: state_d = S_IF;
      S_BR:     state_d = S_IF;
      default:  state_d = S_RST;  // unused encodings recover through reset state
    endcase
  end

  // Output decode. Everything idles at 0 with the PC held unless the state
  // says otherwise; reset forces S_RST, so enables drop asynchronously.
  always_comb begin
    PC_WE      = 1'b0;
    IR_WE      = 1'b0;
    AB_WE      = 1'b0;
    ALUOut_WE  = 1'b0;
    MDR_WE     = 1'b0;
    RF_WE      = 1'b0;
    Mem_RE     = 1'b0;
    Mem_WE     = 1'b0;
    PC_Sel     = PCS_HOLD;
    ALUSrc_Sel = 1'b0;
    WB_Sel     = 1'b0;
    Illegal_Op = 1'b0;
    case (state_q)
      S_IF: begin
        Mem_RE = 1'b1;
        // Instruction word and PC+4 commit only in the cycle the fetch completes
        if (Mem_Ack) begin
          IR_WE  = 1'b1;
          PC_WE  = 1'b1;
          PC_Sel = PCS_SEQ;
        end
      end
      S_DEC: begin
        // An unknown opcode traps back to fetch without touching A/B
        if (op_cls == CLS_ILL) Illegal_Op = 1'b1;
        else                   AB_WE      = 1'b1;
      end
      S_EXE_R: begin
        ALUSrc_Sel = 1'b0;
        ALUOut_WE  = 1'b1;
      end
      S_EXE_I, S_ADDR: begin
        ALUSrc_Sel = 1'b1;
        ALUOut_WE  = 1'b1;
      end
      S_MEM_RD: begin
        Mem_RE = 1'b1;
        MDR_WE = Mem_Ack;
      end
      S_MEM_WR: Mem_WE = 1'b1;
      S_WB_ALU: begin
        RF_WE  = 1'b1;
        WB_Sel = 1'b0;
      end
      S_WB_MEM: begin
        RF_WE  = 1'b1;
        WB_Sel = 1'b1;
      end
      S_BR: begin
        // B is unconditional; BEQ follows the ALU zero flag
        if ((Opcode == OP_B) || Zero) begin
          PC_WE  = 1'b1;
          PC_Sel = PCS_BR;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed bench for multicycle_ctrl. Each step drives inputs just after a
// rising edge, pushes the expected output vector to a scoreboard queue, and
// pops/compares it on the falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  // Expected/observed output vector
  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       ab_we;
    logic       aluout_we;
    logic       mdr_we;
    logic       rf_we;
    logic       mem_re;
    logic       mem_we;
    logic [1:0] pc_sel;
    logic       alusrc;
    logic       wb_sel;
    logic       illegal;
  } out_t;

  localparam logic [5:0] R   = 6'b100000;
  localparam logic [5:0] ADI = 6'b110000;
  localparam logic [5:0] LW  = 6'b001111;
  localparam logic [5:0] SW  = 6'b011111;
  localparam logic [5:0] BR  = 6'b111111;
  localparam logic [5:0] BEQ = 6'b000000;
  localparam logic [5:0] BAD = 6'b010101;

  localparam out_t E_IDLE     = '{pc_sel: 2'b10, default: '0};
  localparam out_t E_IF_ACK   = '{pc_we: 1'b1, ir_we: 1'b1, mem_re: 1'b1, pc_sel: 2'b00, default: '0};
  localparam out_t E_IF_WAIT  = '{mem_re: 1'b1, pc_sel: 2'b10, default: '0};
  localparam out_t E_DEC      = '{ab_we: 1'b1, pc_sel: 2'b10, default: '0};
  localparam out_t E_DEC_ILL  = '{illegal: 1'b1, pc_sel: 2'b10, default: '0};
  localparam out_t E_EXE_R    = '{aluout_we: 1'b1, pc_sel: 2'b10, default: '0};
  localparam out_t E_EXE_I    = '{aluout_we: 1'b1, alusrc: 1'b1, pc_sel: 2'b10, default: '0};
  localparam out_t E_RD_WAIT  = '{mem_re: 1'b1, pc_sel: 2'b10, default: '0};
  localparam out_t E_RD_ACK   = '{mem_re: 1'b1, mdr_we: 1'b1, pc_sel: 2'b10, default: '0};
  localparam out_t E_MEM_WR   = '{mem_we: 1'b1, pc_sel: 2'b10, default: '0};
  localparam out_t E_WB_ALU   = '{rf_we: 1'b1, pc_sel: 2'b10, default: '0};
  localparam out_t E_WB_MEM   = '{rf_we: 1'b1, wb_sel: 1'b1, pc_sel: 2'b10, default: '0};
  localparam out_t E_BR_TAKEN = '{pc_we: 1'b1, pc_sel: 2'b01, default: '0};

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [5:0] Opcode;
  logic       Zero;
  logic       Mem_Ack;
  logic       PC_WE, IR_WE, AB_WE, ALUOut_WE, MDR_WE, RF_WE, Mem_RE, Mem_WE;
  logic [1:0] PC_Sel;
  logic       ALUSrc_Sel, WB_Sel, Illegal_Op;

  out_t  act;
  out_t  sb_q[$];
  string tag_q[$];
  int    checks   = 0;
  int    failures = 0;

  multicycle_ctrl #(.OPC_W(6), .ST_W(4)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Opcode     (Opcode),
    .Zero       (Zero),
    .Mem_Ack    (Mem_Ack),
    .PC_WE      (PC_WE),
    .IR_WE      (IR_WE),
    .AB_WE      (AB_WE),
    .ALUOut_WE  (ALUOut_WE),
    .MDR_WE     (MDR_WE),
    .RF_WE      (RF_WE),
    .Mem_RE     (Mem_RE),
    .Mem_WE     (Mem_WE),
    .PC_Sel     (PC_Sel),
    .ALUSrc_Sel (ALUSrc_Sel),
    .WB_Sel     (WB_Sel),
    .Illegal_Op (Illegal_Op)
  );

  assign act = {PC_WE, IR_WE, AB_WE, ALUOut_WE, MDR_WE, RF_WE, Mem_RE, Mem_WE,
                PC_Sel, ALUSrc_Sel, WB_Sel, Illegal_Op};

  always #5 Clk = ~Clk;

  // Pop the oldest expectation and compare against the live outputs
  task automatic sb_compare();
    out_t  exp;
    string tag;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL sb_empty: observed=%h required=queued_entry", act);
      return;
    end
    exp = sb_q.pop_front();
    tag = tag_q.pop_front();
    checks++;
    assert (act === exp)
      else begin
        failures++;
        $error("FAIL %s: observed=%h required=%h", tag, act, exp);
      end
  endtask

  // One clock cycle: drive, queue expectation, compare on the falling edge
  task automatic cyc(input logic [5:0] op, input logic ack, input logic zero,
                     input out_t exp, input string tag);
    Opcode  = op;
    Mem_Ack = ack;
    Zero    = zero;
    sb_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge Clk);
    sb_compare();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_n = 1'b0;
    Opcode  = R;
    Zero    = 1'b0;
    Mem_Ack = 1'b1;
    @(posedge Clk);
    #1;

    // Reset held for 3 cycles: everything idle, PC held
    cyc(R, 1'b1, 1'b0, E_IDLE, "rst0");
    cyc(R, 1'b1, 1'b0, E_IDLE, "rst1");
    cyc(R, 1'b1, 1'b0, E_IDLE, "rst2");
    Reset_n = 1'b1;
    cyc(R, 1'b1, 1'b0, E_IDLE, "rst_release");

    // R-type: IF, DEC, EXE_R, WB_ALU
    cyc(R, 1'b1, 1'b0, E_IF_ACK, "r_if");
    cyc(R, 1'b0, 1'b0, E_DEC,    "r_dec_ack_ignored");
    cyc(R, 1'b1, 1'b0, E_EXE_R,  "r_exe");
    cyc(R, 1'b1, 1'b0, E_WB_ALU, "r_wb");

    // ADDI with a two-cycle fetch stall
    cyc(ADI, 1'b0, 1'b0, E_IF_WAIT, "addi_if_wait0");
    cyc(ADI, 1'b0, 1'b0, E_IF_WAIT, "addi_if_wait1");
    cyc(ADI, 1'b1, 1'b0, E_IF_ACK,  "addi_if");
    cyc(ADI, 1'b1, 1'b0, E_DEC,     "addi_dec");
    cyc(ADI, 1'b1, 1'b0, E_EXE_I,   "addi_exe");
    cyc(ADI, 1'b1, 1'b0, E_WB_ALU,  "addi_wb");

    // LW with Mem_Ack low for 3 cycles in the read
    cyc(LW, 1'b1, 1'b0, E_IF_ACK,  "lw_if");
    cyc(LW, 1'b1, 1'b0, E_DEC,     "lw_dec");
    cyc(LW, 1'b1, 1'b0, E_EXE_I,   "lw_addr");
    cyc(LW, 1'b0, 1'b0, E_RD_WAIT, "lw_rd_wait0");
    cyc(LW, 1'b0, 1'b0, E_RD_WAIT, "lw_rd_wait1");
    cyc(LW, 1'b0, 1'b0, E_RD_WAIT, "lw_rd_wait2");
    cyc(LW, 1'b1, 1'b0, E_RD_ACK,  "lw_rd_ack");
    cyc(LW, 1'b1, 1'b0, E_WB_MEM,  "lw_wb");

    // BEQ taken, BEQ not taken, B taken regardless of Zero
    cyc(BEQ, 1'b1, 1'b1, E_IF_ACK,   "beq_t_if");
    cyc(BEQ, 1'b1, 1'b1, E_DEC,      "beq_t_dec");
    cyc(BEQ, 1'b1, 1'b1, E_BR_TAKEN, "beq_t_br");
    cyc(BEQ, 1'b1, 1'b0, E_IF_ACK,   "beq_n_if");
    cyc(BEQ, 1'b1, 1'b0, E_DEC,      "beq_n_dec");
    cyc(BEQ, 1'b1, 1'b0, E_IDLE,     "beq_n_br");
    cyc(BR,  1'b1, 1'b0, E_IF_ACK,   "b_if");
    cyc(BR,  1'b1, 1'b0, E_DEC,      "b_dec");
    cyc(BR,  1'b1, 1'b0, E_BR_TAKEN, "b_br");

    // Illegal opcode: pulse in DEC, straight back to fetch
    cyc(BAD, 1'b1, 1'b0, E_IF_ACK,  "ill_if");
    cyc(BAD, 1'b1, 1'b0, E_DEC_ILL, "ill_dec");
    cyc(R,   1'b0, 1'b0, E_IF_WAIT, "ill_back_to_if");
    cyc(R,   1'b1, 1'b0, E_IF_ACK,  "ill_if_done");
    cyc(R,   1'b1, 1'b0, E_DEC,     "r2_dec");
    cyc(R,   1'b1, 1'b0, E_EXE_R,   "r2_exe");
    cyc(R,   1'b1, 1'b0, E_WB_ALU,  "r2_wb");

    // SW completing normally
    cyc(SW, 1'b1, 1'b0, E_IF_ACK, "sw_if");
    cyc(SW, 1'b1, 1'b0, E_DEC,    "sw_dec");
    cyc(SW, 1'b1, 1'b0, E_EXE_I,  "sw_addr");
    cyc(SW, 1'b1, 1'b0, E_MEM_WR, "sw_wr");

    // SW interrupted by reset while the write is pending
    cyc(SW, 1'b1, 1'b0, E_IF_ACK, "sw2_if");
    cyc(SW, 1'b1, 1'b0, E_DEC,    "sw2_dec");
    cyc(SW, 1'b1, 1'b0, E_EXE_I,  "sw2_addr");
    Mem_Ack = 1'b0;
    sb_q.push_back(E_MEM_WR);
    tag_q.push_back("sw2_wr_pending");
    #1;
    sb_compare();
    Reset_n = 1'b0;   // mid-cycle, away from any clock edge
    sb_q.push_back(E_IDLE);
    tag_q.push_back("sw2_async_reset");
    #1;
    sb_compare();
    @(posedge Clk);
    #1;
    cyc(SW, 1'b1, 1'b0, E_IDLE, "rst_mid_hold");
    Reset_n = 1'b1;
    cyc(SW, 1'b1, 1'b0, E_IDLE,   "rst_mid_release");
    cyc(SW, 1'b1, 1'b0, E_IF_ACK, "rst_mid_first_if");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
